// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding logic: forwarding selects,
// in-flight instruction slot record and the producer-match helper.
package pipe_pkg;

  localparam int ZERO_REG_IDX = 31;
  // Slot rd field is sized for the widest supported register index; narrower indices are zero-extended.
  localparam int SLOT_RD_W = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 set_flags;
  } slot_t;

  function automatic logic prod_match(slot_t s, logic [SLOT_RD_W-1:0] r,
                                      logic [SLOT_RD_W-1:0] zero);
    return s.valid && s.reg_write && (s.rd == r) && (r != zero);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand/flag forwarding for the 5-stage pipeline,
// using EX/MEM/WB shadow slots of in-flight instruction attributes.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = ZERO_REG_IDX,
  parameter int FLAG_FWD   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_set_flags,
  input  logic                  id_cb_reg,
  input  logic                  id_cb_flags,
  input  logic                  br_taken,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            fwd_br,
  output logic                  flag_fwd,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [SLOT_RD_W-1:0] ZERO_W     = SLOT_RD_W'(ZERO_REG);
  localparam logic                 FLAG_STALL = (FLAG_FWD == 0);

  function automatic logic [SLOT_RD_W-1:0] widen(logic [REG_ADDR_W-1:0] r);
    return SLOT_RD_W'(r);
  endfunction

  slot_t                 ex_reg, mem_reg, wb_reg;
  logic [REG_ADDR_W-1:0] ex_ra_reg, ex_rb_reg;
  logic                  ex_uses_a_reg, ex_uses_b_reg;

  logic     load_use, br_stall, flag_haz, stall, flush;
  fwd_sel_t sel_a, sel_b, sel_br;

  always_comb begin
    load_use = id_valid && ex_reg.mem_read &&
               ((id_uses_a && prod_match(ex_reg, widen(id_ra), ZERO_W)) ||
                (id_uses_b && prod_match(ex_reg, widen(id_rb), ZERO_W)));

    // A CB operand is read in ID: any EX producer, or a load still in MEM, is too late to forward.
    br_stall = id_cb_reg &&
               (prod_match(ex_reg, widen(id_rb), ZERO_W) ||
                (mem_reg.mem_read && prod_match(mem_reg, widen(id_rb), ZERO_W)));

    flag_haz = id_cb_flags && ex_reg.valid && ex_reg.set_flags;
    stall    = !rst && (load_use || br_stall || (flag_haz && FLAG_STALL));
    flush    = !rst && br_taken && id_valid && !stall;

    sel_a = FWD_RF;
    if (ex_uses_a_reg && prod_match(mem_reg, widen(ex_ra_reg), ZERO_W))     sel_a = FWD_MEM;
    else if (ex_uses_a_reg && prod_match(wb_reg, widen(ex_ra_reg), ZERO_W)) sel_a = FWD_WB;

    sel_b = FWD_RF;
    if (ex_uses_b_reg && prod_match(mem_reg, widen(ex_rb_reg), ZERO_W))     sel_b = FWD_MEM;
    else if (ex_uses_b_reg && prod_match(wb_reg, widen(ex_rb_reg), ZERO_W)) sel_b = FWD_WB;

    sel_br = FWD_RF;
    if (id_cb_reg && !br_stall) begin
      if (prod_match(mem_reg, widen(id_rb), ZERO_W))     sel_br = FWD_MEM;
      else if (prod_match(wb_reg, widen(id_rb), ZERO_W)) sel_br = FWD_WB;
    end
  end

  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign id_ex_bubble = stall;
  assign if_id_flush  = flush;
  assign fwd_a        = rst ? 2'b00 : sel_a;
  assign fwd_b        = rst ? 2'b00 : sel_b;
  assign fwd_br       = rst ? 2'b00 : sel_br;
  assign flag_fwd     = !rst && flag_haz && !FLAG_STALL;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg        <= '0;
      mem_reg       <= '0;
      wb_reg        <= '0;
      ex_ra_reg     <= '0;
      ex_rb_reg     <= '0;
      ex_uses_a_reg <= 1'b0;
      ex_uses_b_reg <= 1'b0;
    end else begin
      wb_reg  <= mem_reg;
      mem_reg <= ex_reg;
      if (stall || !id_valid) begin
        // Bubble reads nothing, so it can never select a forwarding path.
        ex_reg        <= '0;
        ex_ra_reg     <= '0;
        ex_rb_reg     <= '0;
        ex_uses_a_reg <= 1'b0;
        ex_uses_b_reg <= 1'b0;
      end else begin
        ex_reg.valid     <= 1'b1;
        ex_reg.rd        <= widen(id_rd);
        ex_reg.reg_write <= id_reg_write;
        ex_reg.mem_read  <= id_mem_read;
        ex_reg.set_flags <= id_set_flags;
        ex_ra_reg        <= id_ra;
        ex_rb_reg        <= id_rb;
        ex_uses_a_reg    <= id_uses_a;
        ex_uses_b_reg    <= id_uses_b;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomised and directed bench for hazard_fwd_unit; one instance with flag
// forwarding and one with flag stalling, each checked against a pipeline model.
module tb_hazard_fwd_unit;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_a, id_uses_b, id_reg_write, id_mem_read, id_set_flags;
  logic id_cb_reg, id_cb_flags, br_taken;
  logic [4:0] id_ra, id_rb, id_rd;

  logic ph[2], ih[2], bub[2], fl[2], ffw[2];
  logic [1:0] fa[2], fb[2], fbr[2];
  logic [CW-1:0] sc[2], fc[2];

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .FLAG_FWD(1), .CNT_W(CW)) u_dut_ff (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_set_flags(id_set_flags),
    .id_cb_reg(id_cb_reg), .id_cb_flags(id_cb_flags), .br_taken(br_taken),
    .pc_hold(ph[0]), .if_id_hold(ih[0]), .id_ex_bubble(bub[0]), .if_id_flush(fl[0]),
    .fwd_a(fa[0]), .fwd_b(fb[0]), .fwd_br(fbr[0]), .flag_fwd(ffw[0]),
    .stall_count(sc[0]), .flush_count(fc[0])
  );

  hazard_fwd_unit #(.REG_ADDR_W(5), .ZERO_REG(31), .FLAG_FWD(0), .CNT_W(CW)) u_dut_fs (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_set_flags(id_set_flags),
    .id_cb_reg(id_cb_reg), .id_cb_flags(id_cb_flags), .br_taken(br_taken),
    .pc_hold(ph[1]), .if_id_hold(ih[1]), .id_ex_bubble(bub[1]), .if_id_flush(fl[1]),
    .fwd_a(fa[1]), .fwd_b(fb[1]), .fwd_br(fbr[1]), .flag_fwd(ffw[1]),
    .stall_count(sc[1]), .flush_count(fc[1])
  );

  // In-flight instruction as seen by the model; a bubble is all zeros.
  typedef struct packed {
    logic v; logic [4:0] rd; logic rw, mr, sf; logic [4:0] ra, rb; logic ua, ub;
  } ins_t;

  typedef struct packed {
    logic stall, flush, ff; logic [1:0] fa, fb, fbr;
  } exp_t;

  ins_t pipe[2][3];  // [instance][0=EX,1=MEM,2=WB]
  int   scnt[2], fcnt[2];
  exp_t last_exp[2];
  int   checks = 0, errors = 0, cyc = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit writes(ins_t i, logic [4:0] r);
    return i.v && i.rw && (i.rd == r) && (r != 5'd31);
  endfunction

  function automatic logic [1:0] src(ins_t mem, ins_t wb, logic [4:0] r);
    if (writes(mem, r)) return 2'b01;
    if (writes(wb, r))  return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model(int m);
    exp_t e;
    ins_t ex, mem, wb;
    bit lu, bs, fh;
    ex = pipe[m][0]; mem = pipe[m][1]; wb = pipe[m][2];
    e = '0;
    if (rst) return e;
    lu = id_valid && ex.mr && ((id_uses_a && writes(ex, id_ra)) || (id_uses_b && writes(ex, id_rb)));
    bs = id_cb_reg && (writes(ex, id_rb) || (mem.mr && writes(mem, id_rb)));
    fh = id_cb_flags && ex.v && ex.sf;
    e.stall = lu || bs || (fh && m == 1);
    e.ff    = fh && m == 0;
    e.flush = br_taken && id_valid && !e.stall;
    e.fa    = (ex.v && ex.ua) ? src(mem, wb, ex.ra) : 2'b00;
    e.fb    = (ex.v && ex.ub) ? src(mem, wb, ex.rb) : 2'b00;
    e.fbr   = (id_cb_reg && !bs) ? src(mem, wb, id_rb) : 2'b00;
    return e;
  endfunction

  // Check one cycle of both instances, then advance the model across the clock edge.
  task automatic step();
    ins_t ni;
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      string s;
      e = model(m);
      last_exp[m] = e;
      s = (m == 0) ? "ff" : "fs";
      check({s, ".pc_hold"},      32'(ph[m]),  32'(e.stall));
      check({s, ".if_id_hold"},   32'(ih[m]),  32'(e.stall));
      check({s, ".id_ex_bubble"}, 32'(bub[m]), 32'(e.stall));
      check({s, ".if_id_flush"},  32'(fl[m]),  32'(e.flush));
      check({s, ".flag_fwd"},     32'(ffw[m]), 32'(e.ff));
      check({s, ".fwd_a"},        32'(fa[m]),  32'(e.fa));
      check({s, ".fwd_b"},        32'(fb[m]),  32'(e.fb));
      check({s, ".fwd_br"},       32'(fbr[m]), 32'(e.fbr));
      check({s, ".stall_count"},  32'(sc[m]),  32'(scnt[m]));
      check({s, ".flush_count"},  32'(fc[m]),  32'(fcnt[m]));
    end
    $display("cyc %0d rst=%0b v=%0b rd=%0d ra=%0d rb=%0d stall=%0b/%0b flush=%0b/%0b fa=%0d fb=%0d fbr=%0d",
             cyc, rst, id_valid, id_rd, id_ra, id_rb, last_exp[0].stall, last_exp[1].stall,
             last_exp[0].flush, last_exp[1].flush, last_exp[0].fa, last_exp[0].fb, last_exp[0].fbr);
    @(posedge clk);
    ni.v = 1'b1; ni.rd = id_rd; ni.rw = id_reg_write; ni.mr = id_mem_read; ni.sf = id_set_flags;
    ni.ra = id_ra; ni.rb = id_rb; ni.ua = id_uses_a; ni.ub = id_uses_b;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) pipe[m][k] = '0;
        scnt[m] = 0;
        fcnt[m] = 0;
      end else begin
        pipe[m][2] = pipe[m][1];
        pipe[m][1] = pipe[m][0];
        pipe[m][0] = (last_exp[m].stall || !id_valid) ? '0 : ni;
        if (last_exp[m].stall && scnt[m] < CMAX) scnt[m]++;
        if (last_exp[m].flush && fcnt[m] < CMAX) fcnt[m]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_id(logic [4:0] rd, logic rw, logic mr, logic sf, logic [4:0] ra,
                        logic [4:0] rb, logic ua, logic ub, logic cbr, logic cbf, logic bt);
    id_valid = 1'b1; id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_set_flags = sf;
    id_ra = ra; id_rb = rb; id_uses_a = ua; id_uses_b = ub;
    id_cb_reg = cbr; id_cb_flags = cbf; br_taken = bt;
  endtask

  // Present an instruction in ID and hold it while the forwarding instance stalls.
  task automatic issue(logic [4:0] rd, logic rw, logic mr, logic sf, logic [4:0] ra,
                       logic [4:0] rb, logic ua, logic ub, logic cbr, logic cbf, logic bt);
    set_id(rd, rw, mr, sf, ra, rb, ua, ub, cbr, cbf, bt);
    step();
    for (int k = 0; k < 3 && last_exp[0].stall; k++) step();
  endtask

  task automatic nop();
    id_valid = 1'b0; id_cb_reg = 1'b0; id_cb_flags = 1'b0; br_taken = 1'b0;
    step();
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) pipe[m][k] = '0;
      scnt[m] = 0; fcnt[m] = 0; last_exp[m] = '0;
    end
    rst = 1'b1;
    set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // ADD X1 ; ADD X2,X1,X1 ; NOP ; ADD X6,X1,X1
    issue(5'd1, 1, 0, 0, 5'd2, 5'd3, 1, 1, 0, 0, 0);
    issue(5'd2, 1, 0, 0, 5'd1, 5'd1, 1, 1, 0, 0, 0);
    issue(5'd9, 1, 0, 0, 5'd1, 5'd1, 1, 1, 0, 0, 0);
    nop();
    issue(5'd6, 1, 0, 0, 5'd1, 5'd1, 1, 1, 0, 0, 0);
    // LDUR X2 ; ADD X3,X2,X4
    issue(5'd2, 1, 1, 0, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    issue(5'd3, 1, 0, 0, 5'd2, 5'd4, 1, 1, 0, 0, 0);
    nop();
    // ADD X31 ; ADD X5,X31,X31
    issue(5'd31, 1, 0, 0, 5'd1, 5'd1, 1, 1, 0, 0, 0);
    issue(5'd5, 1, 0, 0, 5'd31, 5'd31, 1, 1, 0, 0, 0);
    nop();
    nop();
    // SUBS X0,X1,X2 ; B.EQ taken
    issue(5'd0, 1, 0, 1, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    issue(5'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    nop();
    // ADD X4 ; CBZ X4 taken
    issue(5'd4, 1, 0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    issue(5'd0, 0, 0, 0, 5'd0, 5'd4, 0, 0, 1, 0, 1);
    nop();
    // Reset asserted while a load-use consumer is stalled, then a normal pair.
    issue(5'd2, 1, 1, 0, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    set_id(5'd3, 1, 0, 0, 5'd2, 5'd4, 1, 1, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    issue(5'd7, 1, 0, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0);
    issue(5'd8, 1, 0, 0, 5'd7, 5'd7, 1, 1, 0, 0, 0);
    nop();

    for (int n = 0; n < 700; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rd = pick_reg(); id_ra = pick_reg(); id_rb = pick_reg();
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read = ($urandom_range(0, 2) == 0);
      id_set_flags = ($urandom_range(0, 2) == 0);
      id_uses_a = 1'($urandom_range(0, 1));
      id_uses_b = 1'($urandom_range(0, 1));
      id_cb_reg = ($urandom_range(0, 3) == 0);
      id_cb_flags = ($urandom_range(0, 3) == 0);
      br_taken = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage pipelined ARM core (IF/ID/EX/MEM/WB).
- Tracks the destination, write-enable, load and flag-set attributes of in-flight instructions in internal EX/MEM/WB shadow slots.
- Drives ALU and branch operand forwarding, load-use and branch-operand stalls, flag forwarding, and IF/ID flush on taken branches.
- Sits beside the pipeline registers. Its outputs feed the forwarding muxes, PC hold, IF_ID_Reg hold/flush and ID/EX bubble insertion.

Parameters:
REG_ADDR_W, 5, register-index width
ZERO_REG, 31, index never forwarded or hazarded (XZR)
FLAG_FWD, 1, 1 = forward EX-stage ALU flags to an ID-stage B.cond; 0 = stall instead
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_ra  in  REG_ADDR_W  read register A (post link mux)
id_rb  in  REG_ADDR_W  read register B (post Reg2Loc mux)
id_uses_a  in  1  instruction reads A in EX
id_uses_b  in  1  instruction reads B in EX (includes store data)
id_rd  in  REG_ADDR_W  target register (post branch-link mux)
id_reg_write  in  1  RegWrite
id_mem_read  in  1  memRead (load)
id_set_flags  in  1  set_flags
id_cb_reg  in  1  CBZ/CBNZ: rb needed in ID
id_cb_flags  in  1  B.cond: flags needed in ID
br_taken  in  1  branch resolved taken in ID this cycle
pc_hold  out  1  freeze PC
if_id_hold  out  1  freeze IF/ID register
id_ex_bubble  out  1  load a NOP into ID/EX
if_id_flush  out  1  clear IF/ID
fwd_a  out  2  ALU A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  ALU B/store-data select, same encoding
fwd_br  out  2  ID branch-operand select, same encoding
flag_fwd  out  1  B.cond uses live ALU flags, not the flag register
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of flushes

Behaviour:
- Slots ex/mem/wb each hold valid, rd, reg_write, mem_read, set_flags. The ex slot also holds ra, rb, uses_a, uses_b.
- Every clk edge: wb<=mem and mem<=ex. ex<=ID fields, or a bubble (valid=0) when stall=1 or id_valid=0.
- "Producer match" for slot S and register r: S.valid & S.reg_write & S.rd==r & r!=ZERO_REG.
- fwd_a:
  - 01 if mem matches ex.ra & ex.uses_a;
  - else 10 if wb matches;
  - else 00.
  - fwd_b is the same on ex.rb/uses_b. MEM has priority over WB.
- Load-use stall: id_valid & ex.mem_read & ex matches (id_ra & id_uses_a) or (id_rb & id_uses_b). Exactly one stall cycle; the consumer later gets fwd=10.
- Branch-operand stall (id_cb_reg):
  - ex matches id_rb (any producer) -> stall;
  - mem matches & mem.mem_read -> stall;
  - else fwd_br=01 on a mem match, 10 on a wb match, otherwise 00.
- Flag hazard (id_cb_flags & ex.valid & ex.set_flags): FLAG_FWD=1 -> flag_fwd=1, no stall; FLAG_FWD=0 -> stall one cycle.
- stall = OR of the above. stall drives pc_hold = if_id_hold = id_ex_bubble = 1.
- if_id_flush = br_taken & id_valid & ~stall. Stall wins: a stalled branch is not resolved, so no flush that cycle.
- All control outputs are combinational from slots plus ID inputs. They are forced to 0 while rst=1.
- Counters:
  - stall_count +1 per stall cycle; flush_count +1 per flush cycle.
  - Both saturate at all-ones.
  - Both reset to 0.
- Reset: all slots invalid and counters 0, taking effect on the next edge. A reset during a stall cancels it; the first post-reset cycle shows no hazard.
- Simultaneous MEM and WB matches: MEM is selected. A write to ZERO_REG never matches.

Decomposition:
- Package pipe_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10);
  - slot_t struct (valid, rd, reg_write, mem_read, set_flags);
  - ZERO_REG_IDX constant.
- One sub-module, sat_counter (CNT_W, clk, rst, inc, count), instantiated twice.

Test Plan:
- ADD X1; ADD X2,X1,X1: when the consumer is in EX -> fwd_a=fwd_b=01. With one NOP between them -> 10. No stall.
- LDUR X2; ADD X3,X2,X4: one cycle of pc_hold=if_id_hold=id_ex_bubble=1 -> then fwd_a=10. stall_count 0->1.
- ADD X31,X1,X1; ADD X5,X31,X31: fwd_a=fwd_b=00 and no stall. Same result with id_valid=0 bubbles in the slots.
- SUBS X0,X1,X2; B.EQ: FLAG_FWD=1 -> flag_fwd=1, 0 stalls. FLAG_FWD=0 -> 1 stall, then flag_fwd=0.
- ADD X4; CBZ X4 taken: 1 stall cycle (if_id_flush=0) -> next cycle fwd_br=01, if_id_flush=1 -> flush_count=1.
- Assert rst during a load-use stall -> next cycle all outputs 0, counters 0. The following instruction pair forwards normally.
